// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, fetch opcodes, fetch FSM states
// and the IF/ID pipeline bundle.
package cpu_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;

  localparam logic [3:0] HALT_OP = 4'hF;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic {
    RUN,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pcNext;
    logic               valid;
  } if_id_t;

  function automatic logic [3:0] opcode(
    input logic [INSTR_W-1:0] instr
  );
    return instr[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction memory bus between fetch and instructionMemory.
// Data for an address returns combinationally in the same cycle.
interface fetch_pc_unit_if;
  import cpu_pkg::*;

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;

  modport master (
    output imem_addr,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    output imem_data
  );

endinterface

// File: rtl/fetch_pc_unit_ifid.sv
// IF/ID pipeline register with hold and flush; flush wins
// over hold so a redirect always squashes the wrong path.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hold,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  localparam if_id_t BUBBLE = '{
    instr:  NOP_INSTR,
    pcNext: '0,
    valid:  1'b0
  };

  always_ff @(posedge clk) begin
    if (!rst)
      q <= BUBBLE;
    else if (flush)
      q <= BUBBLE;
    else if (!hold)
      q <= d;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC, redirect/stall/halt control, IF/ID capture
// and a saturating delivered-instruction counter.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  fetch_pc_unit_if.master    imem,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc_next,
  output logic               ifid_valid,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  fetch_state_t      state, stateNxt;
  logic [ADDR_W-1:0] pc, pcNxt, pcPlus, target;
  logic [15:0]       cnt, cntNxt;
  logic              redirect, hold, flush;
  if_id_t            ifidD, ifidQ;

  assign imem.imem_addr = pc;
  assign pcPlus   = pc + ADDR_W'(PC_STEP);
  assign redirect = branch_taken | jump;
  // Branch is older than the jump sitting behind it in ID.
  assign target   = branch_taken ? branch_target : jump_target;

  always_comb begin
    pcNxt    = pc;
    stateNxt = state;
    cntNxt   = cnt;
    hold     = 1'b0;
    flush    = 1'b0;
    ifidD    = '{
      instr:  imem.imem_data,
      pcNext: pcPlus,
      valid:  1'b1
    };
    if (redirect) begin
      pcNxt    = {target[ADDR_W-1:1], 1'b0};
      stateNxt = RUN;
      flush    = 1'b1;
    end else if (stall) begin
      hold = 1'b1;
    end else if (state == HALT) begin
      flush = 1'b1;
    end else begin
      if (cnt != 16'hFFFF)
        cntNxt = cnt + 16'd1;
      if (opcode(imem.imem_data) == HALT_OP)
        stateNxt = HALT;
      else
        pcNxt = pcPlus;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc    <= RESET_PC;
      state <= RUN;
      cnt   <= '0;
    end else begin
      pc    <= pcNxt;
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  ifid_reg u_ifid (
    .clk   (clk),
    .rst   (rst),
    .hold  (hold),
    .flush (flush),
    .d     (ifidD),
    .q     (ifidQ)
  );

  assign ifid_instr   = ifidQ.instr;
  assign ifid_pc_next = ifidQ.pcNext;
  assign ifid_valid   = ifidQ.valid;
  assign halted       = (state == HALT);
  assign fetch_count  = cnt;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: expected post-edge
// outputs are queued per cycle and compared after the edge.
module tb_fetch_pc_unit;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pcn;
    logic        valid;
    logic        halted;
    logic [15:0] cnt;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branchTaken = 1'b0;
  logic [15:0] branchTarget = '0;
  logic        jump = 1'b0;
  logic [15:0] jumpTarget = '0;
  logic [15:0] imemData = '0;
  logic [15:0] ifidInstr, ifidPcNext, fetchCount;
  logic        ifidValid, halted;

  int checks = 0;
  int errors = 0;
  obs_t sb[$];
  obs_t e, o;

  fetch_pc_unit_if imemBus();
  assign imemBus.imem_data = imemData;

  fetch_pc_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branchTaken),
    .branch_target (branchTarget),
    .jump          (jump),
    .jump_target   (jumpTarget),
    .imem          (imemBus),
    .ifid_instr    (ifidInstr),
    .ifid_pc_next  (ifidPcNext),
    .ifid_valid    (ifidValid),
    .halted        (halted),
    .fetch_count   (fetchCount)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    return '{imemBus.imem_addr, ifidInstr, ifidPcNext,
             ifidValid, halted, fetchCount};
  endfunction

  function automatic obs_t mk(
    input logic [15:0] a, input logic [15:0] i,
    input logic [15:0] p, input logic v,
    input logic h, input logic [15:0] c
  );
    return '{a, i, p, v, h, c};
  endfunction

  task automatic drive(
    input logic r, input logic s,
    input logic b, input logic [15:0] bt,
    input logic j, input logic [15:0] jt,
    input logic [15:0] d
  );
    rst = r; stall = s;
    branchTaken = b; branchTarget = bt;
    jump = j; jumpTarget = jt;
    imemData = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sb.push_back(mk(16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 16'h1234);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset got %h exp %h", o, e);
    end
  endtask

  task automatic test_sequential();
    logic [15:0] data [3] = '{16'h1234, 16'h2345, 16'h3456};
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(16'(2*(i+1)), data[i], 16'(2*(i+1)),
                      1, 0, 16'(i+1)));
      drive(1, 0, 0, 0, 0, 0, data[i]);
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL seq%0d got %h exp %h", i, o, e);
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(16'h0006, 16'h3456, 16'h0006, 1, 0, 3));
      drive(1, 1, 0, 0, 0, 0, 16'h4567);
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stall%0d got %h exp %h", i, o, e);
      end
    end
    sb.push_back(mk(16'h0008, 16'h4567, 16'h0008, 1, 0, 4));
    drive(1, 0, 0, 0, 0, 0, 16'h4567);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL stall_resume got %h exp %h", o, e);
    end
  endtask

  task automatic test_redirect_priority();
    sb.push_back(mk(16'h0020, 16'h0000, 16'h0000, 0, 0, 4));
    drive(1, 1, 1, 16'h0021, 1, 16'h0040, 16'h5678);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL br_over_jmp got %h exp %h", o, e);
    end
    sb.push_back(mk(16'h0022, 16'h5678, 16'h0022, 1, 0, 5));
    drive(1, 0, 0, 0, 0, 0, 16'h5678);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL post_branch got %h exp %h", o, e);
    end
  endtask

  task automatic test_halt();
    sb.push_back(mk(16'h000A, 16'h0000, 16'h0000, 0, 0, 5));
    drive(1, 0, 0, 0, 1, 16'h000A, 16'h1111);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL jmp_0a got %h exp %h", o, e);
    end
    sb.push_back(mk(16'h000A, 16'hF000, 16'h000C, 1, 1, 6));
    drive(1, 0, 0, 0, 0, 0, 16'hF000);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL halt_op got %h exp %h", o, e);
    end
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(16'h000A, 16'h0000, 16'h0000, 0, 1, 6));
      drive(1, 0, 0, 0, 0, 0, 16'h1111);
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL halt_bubble%0d got %h exp %h", i, o, e);
      end
    end
    sb.push_back(mk(16'h0010, 16'h0000, 16'h0000, 0, 0, 6));
    drive(1, 0, 1, 16'h0010, 0, 0, 16'h1111);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL halt_exit got %h exp %h", o, e);
    end
    sb.push_back(mk(16'h0012, 16'h2222, 16'h0012, 1, 0, 7));
    drive(1, 0, 0, 0, 0, 0, 16'h2222);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL halt_resume got %h exp %h", o, e);
    end
  endtask

  task automatic test_wrap();
    sb.push_back(mk(16'hFFFE, 16'h0000, 16'h0000, 0, 0, 7));
    drive(1, 0, 0, 0, 1, 16'hFFFE, 16'h3333);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL jmp_fffe got %h exp %h", o, e);
    end
    sb.push_back(mk(16'h0000, 16'h3333, 16'h0000, 1, 0, 8));
    drive(1, 0, 0, 0, 0, 0, 16'h3333);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL wrap got %h exp %h", o, e);
    end
  endtask

  task automatic test_back_to_back_reset();
    sb.push_back(mk(16'h0000, 16'hF00F, 16'h0002, 1, 1, 9));
    drive(1, 0, 0, 0, 0, 0, 16'hF00F);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL halt_at0 got %h exp %h", o, e);
    end
    sb.push_back(mk(16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
    drive(0, 1, 0, 0, 0, 0, 16'hF00F);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL rst_in_halt got %h exp %h", o, e);
    end
    sb.push_back(mk(16'h0002, 16'h1234, 16'h0002, 1, 0, 1));
    drive(1, 0, 0, 0, 0, 0, 16'h1234);
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL rst_resume got %h exp %h", o, e);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_priority();
    test_halt();
    test_wrap();
    test_back_to_back_reset();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
